// File: rtl/zs_sched_pkg.sv
// Shared types for the Zelen-Severo lane scheduler. The types are sized for the largest supported
// configuration, so any legal NUM_LANES/OUT_DEPTH fits without re-parameterising the package.
package zs_sched_pkg;
    localparam int ZS_MAX_LANES = 16;
    localparam int ZS_MAX_DEPTH = 64;
    localparam int ZS_LAT       = 4;

    typedef logic [$clog2(ZS_MAX_LANES)-1:0]   lane_id_t;
    typedef logic [$clog2(ZS_MAX_DEPTH+1)-1:0] credit_t;

    typedef struct packed {
        logic     valid;
        lane_id_t lane_id;
    } tag_t;
endpackage

// File: rtl/zs_lane_fifo.sv
// Per-lane response FIFO with first-word fall-through. The head reads as zero while the FIFO is empty.
module zs_lane_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_cnt;
    logic             w_rd, w_wr;

    assign w_rd = i_rd_en && (r_cnt != '0);
    // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign w_wr = i_wr_en && ((r_cnt != CW'(DEPTH)) || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
        end
    end

    assign o_empty   = (r_cnt == '0);
    assign o_count   = r_cnt;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/zs_lane_scheduler.sv
// Round-robin sharing of one fixed-latency inverse-CDF datapath among NUM_LANES lanes.
// Credits bound the number of in-flight plus buffered results per lane, so a response FIFO never overflows.
module zs_lane_scheduler
    import zs_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int LAT       = ZS_LAT,
    parameter int OUT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       req_valid,
    output logic [NUM_LANES-1:0]       req_ready,
    input  logic [NUM_LANES*WIDTH-1:0] req_t,
    input  logic [NUM_LANES-1:0]       req_negate,
    output logic                       dp_valid_in,
    output logic [WIDTH-1:0]           dp_t,
    output logic                       dp_negate,
    input  logic                       dp_valid_out,
    input  logic [WIDTH-1:0]           dp_z,
    output logic [NUM_LANES-1:0]       rsp_valid,
    input  logic [NUM_LANES-1:0]       rsp_ready,
    output logic [NUM_LANES*WIDTH-1:0] rsp_z,
    output logic                       busy,
    output logic                       tag_err
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    if (NUM_LANES < 2 || NUM_LANES > ZS_MAX_LANES || OUT_DEPTH < 2 || OUT_DEPTH > ZS_MAX_DEPTH ||
        LAT < 1 || FRAC > WIDTH) begin : g_param_chk
        $error("zs_lane_scheduler: unsupported parameter set");
    end

    credit_t          r_credit [NUM_LANES];
    tag_t             r_tag [LAT];
    lane_id_t         r_rr, r_dp_lane, w_win;
    logic             r_dp_valid, r_dp_neg, r_tag_err;
    logic [WIDTH-1:0] r_dp_t, w_t;
    logic             w_any, w_neg, w_tag_live, w_fifo_live;
    logic [NUM_LANES-1:0] w_elig, w_grant, w_wr, w_restore, w_pop, w_empty;
    logic [CW-1:0]    w_cnt [NUM_LANES];
    tag_t             w_tail;

    assign w_tail = r_tag[LAT-1];

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_LANES; i++)
            w_elig[i] = req_valid[i] && (r_credit[i] != '0) && !rst;
    end

    // Rotating priority: first eligible lane at or above r_rr, wrapping.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_any   = 1'b0;
        w_win   = '0;
        w_grant = '0;
        w_t     = '0;
        w_neg   = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!w_any && w_elig[idx]) begin
                w_any = 1'b1;
                w_win = lane_id_t'(idx);
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            w_grant[i] = w_any && (w_win == lane_id_t'(i));
            if (w_grant[i]) begin
                w_t   = req_t[i*WIDTH +: WIDTH];
                w_neg = req_negate[i];
            end
        end
    end

    // A tail tag without a result means the datapath lost it: hand the credit back.
    always_comb begin
        w_wr      = '0;
        w_restore = '0;
        w_pop     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_wr[i]      = w_tail.valid && (w_tail.lane_id == lane_id_t'(i)) && dp_valid_out;
            w_restore[i] = w_tail.valid && (w_tail.lane_id == lane_id_t'(i)) && !dp_valid_out;
            w_pop[i]     = rsp_ready[i] && !w_empty[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr       <= '0;
            r_dp_valid <= 1'b0;
            r_dp_t     <= '0;
            r_dp_neg   <= 1'b0;
            r_dp_lane  <= '0;
            r_tag_err  <= 1'b0;
            for (int k = 0; k < LAT; k++) r_tag[k] <= '0;
            for (int i = 0; i < NUM_LANES; i++) r_credit[i] <= credit_t'(OUT_DEPTH);
        end else begin
            r_dp_valid <= w_any;
            if (w_any) begin
                r_dp_t    <= w_t;
                r_dp_neg  <= w_neg;
                r_dp_lane <= w_win;
                r_rr      <= (w_win == lane_id_t'(NUM_LANES - 1)) ? '0 : w_win + 1'b1;
            end
            r_tag[0] <= '{valid: r_dp_valid, lane_id: r_dp_lane};
            for (int k = 1; k < LAT; k++) r_tag[k] <= r_tag[k-1];
            if (dp_valid_out != w_tail.valid) r_tag_err <= 1'b1;
            for (int i = 0; i < NUM_LANES; i++)
                r_credit[i] <= r_credit[i] - credit_t'(w_grant[i]) + credit_t'(w_pop[i])
                             + credit_t'(w_restore[i]);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        zs_lane_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_wr[g]),
            .i_wr_data (dp_z),
            .i_rd_en   (rsp_ready[g]),
            .o_rd_data (rsp_z[g*WIDTH +: WIDTH]),
            .o_empty   (w_empty[g]),
            .o_count   (w_cnt[g])
        );
        assign rsp_valid[g] = !w_empty[g];
    end

    always_comb begin
        w_tag_live  = r_dp_valid;
        w_fifo_live = 1'b0;
        for (int k = 0; k < LAT; k++) w_tag_live = w_tag_live | r_tag[k].valid;
        for (int i = 0; i < NUM_LANES; i++) w_fifo_live = w_fifo_live | (w_cnt[i] != '0);
    end

    assign req_ready   = w_grant;
    assign dp_valid_in = r_dp_valid;
    assign dp_t        = r_dp_t;
    assign dp_negate   = r_dp_neg;
    assign busy        = w_tag_live || w_fifo_live;
    assign tag_err     = r_tag_err;
endmodule

// File: tb/tb_zs_lane_scheduler.sv
// Randomised bench for zs_lane_scheduler: a transaction-level model (per-lane credit counts, a list of
// outstanding requests with their due cycle, and a list of buffered results) predicts every output.
module tb_zs_lane_scheduler;
    localparam int NL  = 4;
    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int D   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NL-1:0]   req_valid = '0, req_ready, req_negate = '0, rsp_valid, rsp_ready = '0;
    logic [NL*W-1:0] req_t = '0, rsp_z;
    logic            dp_valid_in, dp_negate, dp_valid_out = 1'b0, busy, tag_err;
    logic [W-1:0]    dp_t, dp_z = '0;

    zs_lane_scheduler #(.NUM_LANES(NL), .WIDTH(W), .FRAC(16), .LAT(LAT), .OUT_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_t(req_t),
        .req_negate(req_negate), .dp_valid_in(dp_valid_in), .dp_t(dp_t), .dp_negate(dp_negate),
        .dp_valid_out(dp_valid_out), .dp_z(dp_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [W-1:0] z;
        int         arrive;
        int         acc;
    } txn_t;

    txn_t infl[$];
    txn_t fq[$];
    int   m_cred[NL];
    int   m_rr;
    bit   m_err, m_issue, drop_req, spur_req;
    logic [W-1:0] m_it;
    logic m_in;
    logic hv[LAT+1];
    logic [W-1:0] hz[LAT+1];
    int   cyc = 0, n_chk = 0, n_fail = 0;

    // Stand-in for the shared datapath's arithmetic.
    function automatic logic [W-1:0] zfun(input logic [W-1:0] t, input logic neg);
        logic [W-1:0] z;
        z = {t[15:0], t[31:16]} ^ 32'h5a5a_00c3;
        return neg ? -z : z;
    endfunction

    function automatic int first_idx(input int lane);
        for (int k = 0; k < fq.size(); k++) if (fq[k].lane == lane) return k;
        return -1;
    endfunction

    function automatic logic [NL*W-1:0] rt();
        logic [NL*W-1:0] v;
        for (int i = 0; i < NL; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    function automatic logic [NL-1:0] rn();
        return NL'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        infl.delete();
        fq.delete();
        for (int i = 0; i < NL; i++) m_cred[i] = D;
        m_rr = 0; m_err = 0; m_issue = 0; drop_req = 0; spur_req = 0;
        for (int k = 0; k <= LAT; k++) begin hv[k] = 1'b0; hz[k] = '0; end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = '0; dp_valid_out = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_z", rsp_z, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_tag_err", tag_err, 1'b0);
        chk("rst_dp_valid_in", dp_valid_in, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
    endtask

    // One cycle: check state, drive inputs, run the datapath model, check the grant, advance the model.
    task automatic step(input logic [NL-1:0] v, input logic [NL-1:0] rr,
                        input logic [NL*W-1:0] t, input logic [NL-1:0] n);
        int g, idx;
        bit be, dropped;
        logic [NL-1:0] ev, er;
        while (infl.size() > 0 && infl[0].arrive <= cyc) begin
            fq.push_back(infl[0]);
            void'(infl.pop_front());
        end
        ev = '0;
        for (int i = 0; i < NL; i++) begin
            idx = first_idx(i);
            if (idx >= 0) begin
                ev[i] = 1'b1;
                chk($sformatf("rsp_z[%0d]", i), rsp_z[i*W +: W], fq[idx].z);
            end
        end
        chk("rsp_valid", rsp_valid, ev);
        be = fq.size() > 0;
        foreach (infl[k]) if (infl[k].acc < cyc) be = 1;
        chk("busy", busy, be);
        chk("tag_err", tag_err, m_err);
        chk("dp_valid_in", dp_valid_in, m_issue);
        if (m_issue) chk("dp_issue", {dp_negate, dp_t}, {m_in, m_it});

        req_valid = v; rsp_ready = rr; req_t = t; req_negate = n;

        for (int k = LAT; k > 0; k--) begin hv[k] = hv[k-1]; hz[k] = hz[k-1]; end
        hv[0] = dp_valid_in;
        hz[0] = zfun(dp_t, dp_negate);
        dp_valid_out = hv[LAT];
        dp_z = hv[LAT] ? hz[LAT] : W'($urandom);
        dropped = 0;
        if (drop_req && hv[LAT]) begin
            dp_valid_out = 1'b0; drop_req = 0; dropped = 1; m_err = 1;
        end else if (spur_req && !hv[LAT]) begin
            dp_valid_out = 1'b1; spur_req = 0; m_err = 1;
        end

        #1;
        g = -1;
        for (int k = 0; k < NL; k++) begin
            idx = (m_rr + k) % NL;
            if (g < 0 && v[idx] && m_cred[idx] > 0) g = idx;
        end
        er = (g >= 0) ? (NL'(1) << g) : '0;
        chk("req_ready", req_ready, er);

        m_issue = (g >= 0);
        if (g >= 0) begin
            m_it = t[g*W +: W];
            m_in = n[g];
            m_cred[g]--;
            m_rr = (g + 1) % NL;
            infl.push_back('{lane: g, z: zfun(m_it, m_in), arrive: cyc + LAT + 2, acc: cyc});
        end
        for (int i = 0; i < NL; i++) begin
            if (rr[i]) begin
                idx = first_idx(i);
                if (idx >= 0) begin
                    fq.delete(idx);
                    m_cred[i]++;
                end
            end
        end
        if (dropped && infl.size() > 0) begin
            m_cred[infl[0].lane]++;
            void'(infl.pop_front());
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // single request on lane 2
        step(4'b0100, '1, {32'h0, 32'h0002_0000, 64'h0}, '0);
        repeat (10) step('0, '1, rt(), '0);

        // all lanes contending
        repeat (40) step('1, '1, rt(), rn());
        repeat (10) step('0, '1, rt(), rn());

        // lane 1 backpressured, then a single pop
        repeat (20) step('1, 4'b1101, rt(), rn());
        step('1, '1, rt(), rn());
        repeat (10) step('1, 4'b1101, rt(), rn());
        repeat (15) step('0, '1, rt(), rn());

        // accept and pop together on lane 0 with one credit left
        repeat (3) step(4'b0001, '0, rt(), rn());
        repeat (8) step('0, '0, rt(), rn());
        step(4'b0001, 4'b0001, rt(), rn());
        repeat (3) step(4'b0001, '0, rt(), rn());
        repeat (15) step('0, '1, rt(), rn());

        // lost result, then an unsolicited one
        drop_req = 1;
        step(4'b1000, '1, rt(), rn());
        repeat (12) step('0, '1, rt(), rn());
        spur_req = 1;
        repeat (4) step('0, '1, rt(), rn());

        repeat (300) step(rn(), rn(), rt(), rn());
        repeat (15) step('0, '1, rt(), rn());

        // reset with 2 buffered and 3 in-flight results
        repeat (5) step('1, '0, rt(), rn());
        repeat (2) step('0, '0, rt(), rn());
        do_reset();
        repeat (6) step(4'b0001, '0, rt(), rn());
        repeat (15) step('0, '1, rt(), rn());
        repeat (60) step(rn(), rn(), rt(), rn());
        repeat (15) step('0, '1, rt(), rn());

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
